jelly3_axi4l_register_file: RTL and testbench
=============================================

JELLY3_AXI4L_REGISTER_FILE -- requirements
Module: jelly3_axi4l_register_file

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, data width (32 or 64).
REQ-003 SHALL have parameter REG_NUM, default 16, number of registers (1..256).
REQ-004 SHALL have parameter INIT_VALUE, default 0, reset value of every register.
REQ-005 SHALL have one clock and a synchronous, active-high reset; the clock and reset ports are named as the codebase does.
REQ-006 Port list (name, direction, width, meaning):
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high.
- cke, input, 1: clock enable; 0 freezes all state.
- s_axi4l_awaddr, input, ADDR_BITS: write address.
- s_axi4l_awprot, input, 3: ignored.
- s_axi4l_awvalid / s_axi4l_awready, in/out, 1: AW handshake.
- s_axi4l_wdata, input, DATA_BITS: write data.
- s_axi4l_wstrb, input, DATA_BITS/8: byte strobes.
- s_axi4l_wvalid / s_axi4l_wready, in/out, 1: W handshake.
- s_axi4l_bresp, output, 2: write response.
- s_axi4l_bvalid / s_axi4l_bready, out/in, 1: B handshake.
- s_axi4l_araddr, input, ADDR_BITS: read address.
- s_axi4l_arprot, input, 3: ignored.
- s_axi4l_arvalid / s_axi4l_arready, in/out, 1: AR handshake.
- s_axi4l_rdata, output, DATA_BITS: read data.
- s_axi4l_rresp, output, 2: read response.
- s_axi4l_rvalid / s_axi4l_rready, out/in, 1: R handshake.
- out_regs, output, REG_NUM*DATA_BITS: register contents, reg i at bits [i*DATA_BITS +: DATA_BITS].

Function
REQ-007 A handshake SHALL count only on a rising edge with cke=1 and valid=ready=1; with cke=0 no state changes.
REQ-008 Register index SHALL be addr >> log2(DATA_BITS/8); low byte-offset bits ignored; index >= REG_NUM is out of range.
REQ-009 AW and W SHALL be captured independently into one-entry holds; awready = !aw_hold, wready = !w_hold (registered, not combinational from valid).
REQ-010 Commit SHALL occur on the first enabled edge where aw_hold && w_hold && (!bvalid || bready); on commit both holds clear and bvalid=1 from the next cycle.
REQ-011 On commit to an in-range index, each byte with wstrb=1 SHALL be updated, others unchanged; bresp=2'b00.
REQ-012 On commit to an out-of-range index, no register SHALL change; bresp=2'b10 (SLVERR).
REQ-013 AW and W accepted on the same edge N SHALL commit at edge N+1 (bvalid and new out_regs visible after N+1), given B free.
REQ-014 bvalid SHALL hold with stable bresp until bready; a new commit while bvalid && bready SHALL keep bvalid=1 back-to-back.
REQ-015 arready SHALL equal !rvalid || rready; AR accepted at edge N SHALL present rvalid=1 after N with rdata/rresp stable until rready.
REQ-016 Read of in-range index SHALL return the register value before any commit on the same edge, rresp=2'b00; out-of-range SHALL return rdata=0, rresp=2'b10.
REQ-017 Read and write channels SHALL operate concurrently with no mutual stalls.

Reset
REQ-018 On reset=1 at an edge (regardless of cke): registers=INIT_VALUE, holds cleared, awready=1, wready=1, bvalid=0, bresp=0, arready=1, rvalid=0, rdata=0, rresp=0; in-flight transactions are discarded.

Verification
REQ-019 Write 0x12345678 strb 0xF to reg 3 (addr 0x00C), AW/W same cycle -> bvalid 2 cycles later, bresp=0, out_regs[3]=0x12345678; read 0x00C -> rdata=0x12345678, rresp=0.
REQ-020 W issued 5 cycles before AW, strb 0x3, data 0xAAAABBBB onto 0x12345678 -> reg=0x1234BBBB; wready stays 0 until commit.
REQ-021 Write to addr 0x040 (index 16) -> bresp=2'b10, all registers unchanged; read 0x040 -> rdata=0, rresp=2'b10.
REQ-022 bready=0 for 10 cycles with second write pending -> second commit waits; bresp of first stable; both B responses delivered in order.
REQ-023 Random valid/ready throttling (≈30%) on all five channels, 1000 random accesses -> reads match scoreboard model.
REQ-024 Reset asserted with AW held and rvalid=1 -> next cycle rvalid=0, bvalid=0, awready=1, all registers=INIT_VALUE.

Source files
------------

// File: rtl/jelly3_axi4l_register_file.sv
// AXI4-Lite slave holding REG_NUM byte-writable registers, mirrored flat on out_regs.
// Latency: write commits one edge after both AW and W are held; read data registered one edge after AR.
// Backpressure: AW/W stall while their one-entry hold is full, an unaccepted B blocks commit, AR stalls while R is unread.
// Ports: clk/reset/cke; AXI4-Lite slave s_axi4l_aw*/w*/b*/ar*/r*; out_regs = reg i at [i*DATA_BITS +: DATA_BITS].
module jelly3_axi4l_register_file #(
  parameter int                   ADDR_BITS  = 12,
  parameter int                   DATA_BITS  = 32,
  parameter int                   REG_NUM    = 16,
  parameter logic [DATA_BITS-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cke,

  input  logic [ADDR_BITS-1:0]         s_axi4l_awaddr,
  input  logic [2:0]                   s_axi4l_awprot,
  input  logic                         s_axi4l_awvalid,
  output logic                         s_axi4l_awready,
  input  logic [DATA_BITS-1:0]         s_axi4l_wdata,
  input  logic [DATA_BITS/8-1:0]       s_axi4l_wstrb,
  input  logic                         s_axi4l_wvalid,
  output logic                         s_axi4l_wready,
  output logic [1:0]                   s_axi4l_bresp,
  output logic                         s_axi4l_bvalid,
  input  logic                         s_axi4l_bready,

  input  logic [ADDR_BITS-1:0]         s_axi4l_araddr,
  input  logic [2:0]                   s_axi4l_arprot,
  input  logic                         s_axi4l_arvalid,
  output logic                         s_axi4l_arready,
  output logic [DATA_BITS-1:0]         s_axi4l_rdata,
  output logic [1:0]                   s_axi4l_rresp,
  output logic                         s_axi4l_rvalid,
  input  logic                         s_axi4l_rready,

  output logic [REG_NUM*DATA_BITS-1:0] out_regs
);

  localparam int         STRB_BITS   = DATA_BITS / 8;
  localparam int         ADDR_SHIFT  = $clog2(STRB_BITS);
  // Index compare width: holds any address-derived index and REG_NUM (<= 256) without truncation.
  localparam int         IDX_BITS    = ADDR_BITS + 9;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [IDX_BITS-1:0] reg_index(input logic [ADDR_BITS-1:0] addr);
    return IDX_BITS'(addr >> ADDR_SHIFT);
  endfunction

  logic [DATA_BITS-1:0] regs [REG_NUM];

  logic                 aw_hold;
  logic [ADDR_BITS-1:0] aw_addr;
  logic                 w_hold;
  logic [DATA_BITS-1:0] w_data;
  logic [STRB_BITS-1:0] w_strb;

  logic [IDX_BITS-1:0]  wr_index;
  logic [IDX_BITS-1:0]  rd_index;
  logic                 wr_in_range;
  logic                 commit;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_in_range;

  logic                 unused_prot;
  assign unused_prot = ^{s_axi4l_awprot, s_axi4l_arprot};

  assign wr_index    = reg_index(aw_addr);
  assign rd_index    = reg_index(s_axi4l_araddr);
  assign wr_in_range = (wr_index < IDX_BITS'(REG_NUM));

  // Ready signals come straight from state, never from the valid inputs.
  assign s_axi4l_awready = !aw_hold;
  assign s_axi4l_wready  = !w_hold;
  assign s_axi4l_arready = !s_axi4l_rvalid || s_axi4l_rready;

  // A commit needs both halves of the write and a free (or draining) B slot.
  assign commit = aw_hold && w_hold && (!s_axi4l_bvalid || s_axi4l_bready);

  // Read mux; an index matching no register leaves rd_in_range low.
  always_comb begin
    rd_data     = '0;
    rd_in_range = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd_index == IDX_BITS'(i)) begin
        rd_data     = regs[i];
        rd_in_range = 1'b1;
      end
    end
  end

  always_comb begin
    out_regs = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      out_regs[i*DATA_BITS +: DATA_BITS] = regs[i];
    end
  end

  // Write path: AW/W holds, commit and B response.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_hold        <= 1'b0;
      aw_addr        <= '0;
      w_hold         <= 1'b0;
      w_data         <= '0;
      w_strb         <= '0;
      s_axi4l_bvalid <= 1'b0;
      s_axi4l_bresp  <= RESP_OKAY;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= INIT_VALUE;
      end
    end else if (cke) begin
      if (s_axi4l_awvalid && s_axi4l_awready) begin
        aw_hold <= 1'b1;
        aw_addr <= s_axi4l_awaddr;
      end
      if (s_axi4l_wvalid && s_axi4l_wready) begin
        w_hold <= 1'b1;
        w_data <= s_axi4l_wdata;
        w_strb <= s_axi4l_wstrb;
      end

      if (commit) begin
        // Holds are full here, so no AW/W handshake competes with these clears.
        aw_hold        <= 1'b0;
        w_hold         <= 1'b0;
        s_axi4l_bvalid <= 1'b1;
        s_axi4l_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < REG_NUM; i++) begin
          if (wr_index == IDX_BITS'(i)) begin
            for (int b = 0; b < STRB_BITS; b++) begin
              if (w_strb[b]) begin
                regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
              end
            end
          end
        end
      end else if (s_axi4l_bready) begin
        s_axi4l_bvalid <= 1'b0;
      end
    end
  end

  // Read path: a single registered R slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi4l_rvalid <= 1'b0;
      s_axi4l_rdata  <= '0;
      s_axi4l_rresp  <= RESP_OKAY;
    end else if (cke) begin
      if (s_axi4l_arvalid && s_axi4l_arready) begin
        s_axi4l_rvalid <= 1'b1;
        s_axi4l_rdata  <= rd_data;
        s_axi4l_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi4l_rready) begin
        s_axi4l_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly3_axi4l_register_file.sv
module tb_jelly3_axi4l_register_file;

  localparam int          ADDR_BITS  = 12;
  localparam int          DATA_BITS  = 32;
  localparam int          REG_NUM    = 16;
  localparam logic [31:0] INIT_VALUE = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [11:0] s_axi4l_awaddr;
  logic [2:0]  s_axi4l_awprot;
  logic        s_axi4l_awvalid;
  logic        s_axi4l_awready;
  logic [31:0] s_axi4l_wdata;
  logic [3:0]  s_axi4l_wstrb;
  logic        s_axi4l_wvalid;
  logic        s_axi4l_wready;
  logic [1:0]  s_axi4l_bresp;
  logic        s_axi4l_bvalid;
  logic        s_axi4l_bready;
  logic [11:0] s_axi4l_araddr;
  logic [2:0]  s_axi4l_arprot;
  logic        s_axi4l_arvalid;
  logic        s_axi4l_arready;
  logic [31:0] s_axi4l_rdata;
  logic [1:0]  s_axi4l_rresp;
  logic        s_axi4l_rvalid;
  logic        s_axi4l_rready;
  logic [REG_NUM*DATA_BITS-1:0] out_regs;

  int total = 0;
  int bad   = 0;

  // Reference model: plain array of register values.
  logic [31:0] model [REG_NUM];

  always #5 clk = ~clk;

  jelly3_axi4l_register_file #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .REG_NUM   (REG_NUM),
    .INIT_VALUE(INIT_VALUE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cke            (cke),
    .s_axi4l_awaddr (s_axi4l_awaddr),
    .s_axi4l_awprot (s_axi4l_awprot),
    .s_axi4l_awvalid(s_axi4l_awvalid),
    .s_axi4l_awready(s_axi4l_awready),
    .s_axi4l_wdata  (s_axi4l_wdata),
    .s_axi4l_wstrb  (s_axi4l_wstrb),
    .s_axi4l_wvalid (s_axi4l_wvalid),
    .s_axi4l_wready (s_axi4l_wready),
    .s_axi4l_bresp  (s_axi4l_bresp),
    .s_axi4l_bvalid (s_axi4l_bvalid),
    .s_axi4l_bready (s_axi4l_bready),
    .s_axi4l_araddr (s_axi4l_araddr),
    .s_axi4l_arprot (s_axi4l_arprot),
    .s_axi4l_arvalid(s_axi4l_arvalid),
    .s_axi4l_arready(s_axi4l_arready),
    .s_axi4l_rdata  (s_axi4l_rdata),
    .s_axi4l_rresp  (s_axi4l_rresp),
    .s_axi4l_rvalid (s_axi4l_rvalid),
    .s_axi4l_rready (s_axi4l_rready),
    .out_regs       (out_regs)
  );

  function automatic int idx_of(input logic [11:0] addr);
    return int'(addr) / 4;
  endfunction

  function automatic logic [1:0] model_resp(input logic [11:0] addr);
    return (idx_of(addr) < REG_NUM) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    return (idx_of(addr) < REG_NUM) ? model[idx_of(addr)] : 32'h0;
  endfunction

  function automatic void model_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    k = idx_of(addr);
    if (k < REG_NUM) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[k][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < REG_NUM; i++) model[i] = INIT_VALUE;
  endfunction

  function automatic logic [11:0] rand_addr();
    logic [11:0] a;
    if ($urandom_range(0, 9) < 8) a = 12'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
    else                          a = 12'($urandom);
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < REG_NUM; i++) begin
      check($sformatf("%s_reg%0d", tag, i), 64'(out_regs[i*DATA_BITS +: DATA_BITS]), 64'(model[i]));
    end
  endtask

  // One transaction (write, read, or both concurrently) with valid/ready throttled at thr percent.
  task automatic access(input bit do_w, input logic [11:0] waddr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit do_r, input logic [11:0] raddr,
                        input int thr, output logic [1:0] bresp_o,
                        output logic [31:0] rdata_o, output logic [1:0] rresp_o);
    bit aw_done, w_done, ar_done, b_done, r_done;
    bit aw_f, w_f, ar_f, b_f, r_f;
    int cyc;
    aw_done = !do_w; w_done = !do_w; b_done = !do_w;
    ar_done = !do_r; r_done = !do_r;
    bresp_o = '0; rdata_o = '0; rresp_o = '0;
    s_axi4l_awaddr = waddr;
    s_axi4l_wdata  = wdata;
    s_axi4l_wstrb  = wstrb;
    s_axi4l_araddr = raddr;
    cyc = 0;
    while (!(b_done && r_done) && cyc < 300) begin
      if (!aw_done && !s_axi4l_awvalid) s_axi4l_awvalid = ($urandom_range(0, 99) < thr);
      if (!w_done  && !s_axi4l_wvalid)  s_axi4l_wvalid  = ($urandom_range(0, 99) < thr);
      if (!ar_done && !s_axi4l_arvalid) s_axi4l_arvalid = ($urandom_range(0, 99) < thr);
      s_axi4l_bready = !b_done && ($urandom_range(0, 99) < thr);
      s_axi4l_rready = !r_done && ($urandom_range(0, 99) < thr);
      #1;
      aw_f = s_axi4l_awvalid && s_axi4l_awready;
      w_f  = s_axi4l_wvalid  && s_axi4l_wready;
      ar_f = s_axi4l_arvalid && s_axi4l_arready;
      b_f  = s_axi4l_bvalid  && s_axi4l_bready;
      r_f  = s_axi4l_rvalid  && s_axi4l_rready;
      if (b_f) begin bresp_o = s_axi4l_bresp; b_done = 1'b1; end
      if (r_f) begin rdata_o = s_axi4l_rdata; rresp_o = s_axi4l_rresp; r_done = 1'b1; end
      tick();
      if (aw_f) begin s_axi4l_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_f)  begin s_axi4l_wvalid  = 1'b0; w_done  = 1'b1; end
      if (ar_f) begin s_axi4l_arvalid = 1'b0; ar_done = 1'b1; end
      cyc++;
    end
    s_axi4l_awvalid = 1'b0; s_axi4l_wvalid = 1'b0; s_axi4l_arvalid = 1'b0;
    s_axi4l_bready  = 1'b0; s_axi4l_rready = 1'b0;
    check("access_done", 64'(b_done && r_done), 64'd1);
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    logic [11:0] wa, ra;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rr, exp_br;
    int          mode;

    reset = 1'b1; cke = 1'b1;
    s_axi4l_awaddr = '0; s_axi4l_awprot = '0; s_axi4l_awvalid = 1'b0;
    s_axi4l_wdata  = '0; s_axi4l_wstrb  = '0; s_axi4l_wvalid  = 1'b0;
    s_axi4l_bready = 1'b0;
    s_axi4l_araddr = '0; s_axi4l_arprot = '0; s_axi4l_arvalid = 1'b0;
    s_axi4l_rready = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_awready", 64'(s_axi4l_awready), 64'd1);
    check("rst_wready",  64'(s_axi4l_wready),  64'd1);
    check("rst_bvalid",  64'(s_axi4l_bvalid),  64'd0);
    check("rst_bresp",   64'(s_axi4l_bresp),   64'd0);
    check("rst_arready", 64'(s_axi4l_arready), 64'd1);
    check("rst_rvalid",  64'(s_axi4l_rvalid),  64'd0);
    check("rst_rdata",   64'(s_axi4l_rdata),   64'd0);
    check("rst_rresp",   64'(s_axi4l_rresp),   64'd0);
    check_all_regs("rst");

    // Full write to reg 3 with AW and W on the same edge, then read back
    s_axi4l_awaddr = 12'h00C; s_axi4l_awvalid = 1'b1;
    s_axi4l_wdata = 32'h1234_5678; s_axi4l_wstrb = 4'hF; s_axi4l_wvalid = 1'b1;
    s_axi4l_bready = 1'b1;
    tick();
    s_axi4l_awvalid = 1'b0; s_axi4l_wvalid = 1'b0;
    check("w1_bvalid_early", 64'(s_axi4l_bvalid),  64'd0);
    check("w1_awready_held", 64'(s_axi4l_awready), 64'd0);
    tick();
    check("w1_bvalid", 64'(s_axi4l_bvalid), 64'd1);
    check("w1_bresp",  64'(s_axi4l_bresp),  64'd0);
    check("w1_reg3",   64'(out_regs[3*32 +: 32]), 64'h1234_5678);
    model_write(12'h00C, 32'h1234_5678, 4'hF);
    tick();
    check("w1_bvalid_drop", 64'(s_axi4l_bvalid), 64'd0);
    s_axi4l_bready = 1'b0;
    s_axi4l_araddr = 12'h00C; s_axi4l_arvalid = 1'b1;
    tick();
    s_axi4l_arvalid = 1'b0;
    check("r1_rvalid",  64'(s_axi4l_rvalid),  64'd1);
    check("r1_rdata",   64'(s_axi4l_rdata),   64'h1234_5678);
    check("r1_rresp",   64'(s_axi4l_rresp),   64'd0);
    check("r1_arready", 64'(s_axi4l_arready), 64'd0);
    tick();
    check("r1_rvalid_hold", 64'(s_axi4l_rvalid), 64'd1);
    check("r1_rdata_hold",  64'(s_axi4l_rdata),  64'h1234_5678);
    s_axi4l_rready = 1'b1;
    tick();
    check("r1_rvalid_drop", 64'(s_axi4l_rvalid), 64'd0);
    s_axi4l_rready = 1'b0;

    // W five cycles ahead of AW, partial strobes
    s_axi4l_wdata = 32'hAAAA_BBBB; s_axi4l_wstrb = 4'h3; s_axi4l_wvalid = 1'b1;
    s_axi4l_bready = 1'b1;
    tick();
    s_axi4l_wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("w2_wready_wait%0d", k), 64'(s_axi4l_wready), 64'd0);
      tick();
    end
    s_axi4l_awaddr = 12'h00C; s_axi4l_awvalid = 1'b1;
    tick();
    s_axi4l_awvalid = 1'b0;
    check("w2_wready_aw", 64'(s_axi4l_wready), 64'd0);
    check("w2_bvalid_aw", 64'(s_axi4l_bvalid), 64'd0);
    tick();
    check("w2_bvalid", 64'(s_axi4l_bvalid), 64'd1);
    check("w2_bresp",  64'(s_axi4l_bresp),  64'd0);
    check("w2_wready", 64'(s_axi4l_wready), 64'd1);
    check("w2_reg3",   64'(out_regs[3*32 +: 32]), 64'h1234_BBBB);
    model_write(12'h00C, 32'hAAAA_BBBB, 4'h3);
    tick();
    check("w2_bvalid_drop", 64'(s_axi4l_bvalid), 64'd0);
    s_axi4l_bready = 1'b0;

    // Out-of-range write and read
    access(1'b1, 12'h040, 32'hFFFF_FFFF, 4'hF, 1'b0, 12'h000, 100, br, rd, rr);
    check("oor_bresp", 64'(br), 64'h2);
    check_all_regs("oor");
    access(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h040, 100, br, rd, rr);
    check("oor_rdata", 64'(rd), 64'h0);
    check("oor_rresp", 64'(rr), 64'h2);

    // cke freeze, then reset with AW held and R pending
    s_axi4l_awaddr = 12'h014; s_axi4l_awvalid = 1'b1;
    s_axi4l_araddr = 12'h00C; s_axi4l_arvalid = 1'b1;
    tick();
    s_axi4l_awvalid = 1'b0; s_axi4l_arvalid = 1'b0;
    check("pre_awready", 64'(s_axi4l_awready), 64'd0);
    check("pre_rvalid",  64'(s_axi4l_rvalid),  64'd1);
    check("pre_rdata",   64'(s_axi4l_rdata),   64'(model[3]));
    cke = 1'b0;
    s_axi4l_wdata = 32'h5555_5555; s_axi4l_wstrb = 4'hF; s_axi4l_wvalid = 1'b1;
    s_axi4l_rready = 1'b1;
    repeat (3) tick();
    check("cke_rvalid", 64'(s_axi4l_rvalid), 64'd1);
    check("cke_bvalid", 64'(s_axi4l_bvalid), 64'd0);
    check("cke_wready", 64'(s_axi4l_wready), 64'd1);
    check("cke_reg5",   64'(out_regs[5*32 +: 32]), 64'(model[5]));
    s_axi4l_wvalid = 1'b0; s_axi4l_rready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; cke = 1'b1;
    model_reset();
    check("r024_rvalid",  64'(s_axi4l_rvalid),  64'd0);
    check("r024_bvalid",  64'(s_axi4l_bvalid),  64'd0);
    check("r024_bresp",   64'(s_axi4l_bresp),   64'd0);
    check("r024_awready", 64'(s_axi4l_awready), 64'd1);
    check("r024_wready",  64'(s_axi4l_wready),  64'd1);
    check("r024_arready", 64'(s_axi4l_arready), 64'd1);
    check("r024_rdata",   64'(s_axi4l_rdata),   64'd0);
    check_all_regs("r024");
    // The discarded AW must not pair with a fresh W.
    s_axi4l_wdata = 32'h0BAD_F00D; s_axi4l_wstrb = 4'hF; s_axi4l_wvalid = 1'b1;
    s_axi4l_bready = 1'b1;
    tick();
    s_axi4l_wvalid = 1'b0;
    repeat (2) tick();
    check("r024_no_commit", 64'(s_axi4l_bvalid), 64'd0);
    s_axi4l_awaddr = 12'h014; s_axi4l_awvalid = 1'b1;
    tick();
    s_axi4l_awvalid = 1'b0;
    tick();
    check("r024_commit", 64'(s_axi4l_bvalid), 64'd1);
    check("r024_reg5",   64'(out_regs[5*32 +: 32]), 64'h0BAD_F00D);
    model_write(12'h014, 32'h0BAD_F00D, 4'hF);
    tick();
    s_axi4l_bready = 1'b0;

    // B backpressure: SLVERR response held 10 cycles while an OKAY write waits
    s_axi4l_awaddr = 12'h044; s_axi4l_awvalid = 1'b1;
    s_axi4l_wdata = 32'h1111_1111; s_axi4l_wstrb = 4'hF; s_axi4l_wvalid = 1'b1;
    tick();
    s_axi4l_awvalid = 1'b0; s_axi4l_wvalid = 1'b0;
    tick();
    check("bp_first_bvalid", 64'(s_axi4l_bvalid), 64'd1);
    check("bp_first_bresp",  64'(s_axi4l_bresp),  64'h2);
    s_axi4l_awaddr = 12'h008; s_axi4l_awvalid = 1'b1;
    s_axi4l_wdata = 32'hC0DE_0002; s_axi4l_wstrb = 4'hF; s_axi4l_wvalid = 1'b1;
    tick();
    s_axi4l_awvalid = 1'b0; s_axi4l_wvalid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold_bvalid%0d", k), 64'(s_axi4l_bvalid), 64'd1);
      check($sformatf("bp_hold_bresp%0d", k),  64'(s_axi4l_bresp),  64'h2);
      check($sformatf("bp_hold_reg2_%0d", k),  64'(out_regs[2*32 +: 32]), 64'(model[2]));
      tick();
    end
    s_axi4l_bready = 1'b1;
    tick();
    check("bp_second_bvalid", 64'(s_axi4l_bvalid), 64'd1);
    check("bp_second_bresp",  64'(s_axi4l_bresp),  64'h0);
    check("bp_second_reg2",   64'(out_regs[2*32 +: 32]), 64'hC0DE_0002);
    model_write(12'h008, 32'hC0DE_0002, 4'hF);
    tick();
    check("bp_bvalid_drop", 64'(s_axi4l_bvalid), 64'd0);
    s_axi4l_bready = 1'b0;

    // Random throttled traffic, concurrent read/write on distinct registers
    for (int n = 0; n < 1000; n++) begin
      mode = $urandom_range(0, 2);
      wa = rand_addr();
      ra = rand_addr();
      wd = $urandom;
      ws = 4'($urandom);
      if (mode == 2 && idx_of(wa) < REG_NUM && idx_of(ra) == idx_of(wa))
        ra = 12'(((idx_of(wa) + 1) % REG_NUM) * 4);
      exp_rd = model_read(ra);
      exp_rr = model_resp(ra);
      exp_br = model_resp(wa);
      access(mode != 1, wa, wd, ws, mode != 0, ra, 70, br, rd, rr);
      if (mode != 1) begin
        check($sformatf("rnd%0d_bresp", n), 64'(br), 64'(exp_br));
        model_write(wa, wd, ws);
      end
      if (mode != 0) begin
        check($sformatf("rnd%0d_rdata", n), 64'(rd), 64'(exp_rd));
        check($sformatf("rnd%0d_rresp", n), 64'(rr), 64'(exp_rr));
      end
    end
    check_all_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
